// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution at EX/MEM: one registered pcload pulse plus redirect target, then a
// shadow window that ignores wrong-path control flow. Optional perf counters under BRU_PERF_CNT_EN.
module branch_resolve_unit #(
   parameter int SHADOW_CYCLES = 2,
   parameter int XLEN          = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            ex_valid,
   input  logic            ex_beq,
   input  logic            ex_bne,
   input  logic            ex_jump,
   input  logic            ex_zero,
   input  logic [XLEN-1:0] ex_pc_plus4,
   input  logic [XLEN-1:0] ex_imm,
   input  logic [25:0]     ex_jaddr,
   output logic            pcload,
   output logic [XLEN-1:0] pc_target,
   output logic            busy
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [31:0]     perf_branches,
   output logic [31:0]     perf_taken
`endif
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_REDIRECT = 2'd1;
   localparam logic [1:0] ST_SHADOW   = 2'd2;
   localparam logic [2:0] SHADOW_INIT = 3'(SHADOW_CYCLES - 1);

   logic [1:0]      state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            pcload_q, pcload_d;
   logic [XLEN-1:0] target_q, target_d;

   logic            is_ctl;
   logic            taken;
   logic [XLEN-1:0] br_target;
   logic [XLEN-1:0] j_target;

   assign is_ctl    = ex_valid & (ex_jump | ex_beq | ex_bne);
   assign br_target = ex_pc_plus4 + (ex_imm << 2);
   assign j_target  = {ex_pc_plus4[XLEN-1:28], ex_jaddr, 2'b00};

   // Type priority jump > beq > bne decides which condition applies.
   always_comb begin
      taken = 1'b0;
      if (ex_jump)     taken = 1'b1;
      else if (ex_beq) taken = ex_zero;
      else if (ex_bne) taken = ~ex_zero;
      taken = taken & ex_valid;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pcload_d = pcload_q;
      target_d = target_q;
      if (!stall) begin
         case (state_q)
            ST_IDLE: begin
               if (taken) begin
                  state_d  = ST_REDIRECT;
                  pcload_d = 1'b1;
                  target_d = ex_jump ? j_target : br_target;
               end
            end
            ST_REDIRECT: begin
               state_d  = ST_SHADOW;
               pcload_d = 1'b0;
               cnt_d    = SHADOW_INIT;
            end
            ST_SHADOW: begin
               if (cnt_q == 3'd0) state_d = ST_IDLE;
               else               cnt_d   = cnt_q - 3'd1;
            end
            default: begin
               state_d  = ST_IDLE;
               pcload_d = 1'b0;
               cnt_d    = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 3'd0;
         pcload_q <= 1'b0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pcload_q <= pcload_d;
         target_q <= target_d;
      end
   end

   assign pcload    = pcload_q;
   assign pc_target = target_q;
   assign busy      = (state_q != ST_IDLE);

`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_branches_q, perf_branches_d;
   logic [31:0] perf_taken_q, perf_taken_d;
   logic        sampled;

   // Only instructions seen by an unstalled IDLE FSM count; shadow-window ones are wrong-path.
   assign sampled = (state_q == ST_IDLE) & ~stall & is_ctl;

   always_comb begin
      perf_branches_d = perf_branches_q;
      perf_taken_d    = perf_taken_q;
      if (sampled)         perf_branches_d = perf_branches_q + 32'd1;
      if (sampled & taken) perf_taken_d    = perf_taken_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_branches_q <= 32'd0;
         perf_taken_q    <= 32'd0;
      end else begin
         perf_branches_q <= perf_branches_d;
         perf_taken_q    <= perf_taken_d;
      end
   end

   assign perf_branches = perf_branches_q;
   assign perf_taken    = perf_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: stimulus pushes expected redirect targets,
// a negedge monitor pops one per observed pcload cycle.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_beq = 1'b0;
   logic        ex_bne = 1'b0;
   logic        ex_jump = 1'b0;
   logic        ex_zero = 1'b0;
   logic [31:0] ex_pc_plus4 = '0;
   logic [31:0] ex_imm = '0;
   logic [25:0] ex_jaddr = '0;
   logic        pcload;
   logic [31:0] pc_target;
   logic        busy;
`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_branches;
   logic [31:0] perf_taken;
`endif

   int total = 0;
   int bad   = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   branch_resolve_unit #(.SHADOW_CYCLES(2), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
      .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_jump(ex_jump), .ex_zero(ex_zero),
      .ex_pc_plus4(ex_pc_plus4), .ex_imm(ex_imm), .ex_jaddr(ex_jaddr),
      .pcload(pcload), .pc_target(pc_target), .busy(busy)
`ifdef BRU_PERF_CNT_EN
      , .perf_branches(perf_branches), .perf_taken(perf_taken)
`endif
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: every cycle with pcload high must match the oldest expected target.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && (pcload !== 1'b0)) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_pcload actual=%h required=no_pcload", pc_target);
            end else begin
               e = sb.pop_front();
               if (pcload !== 1'b1 || pc_target !== e) begin
                  bad++;
                  $display("FAIL redirect actual=%b/%h required=1/%h", pcload, pc_target, e);
               end
            end
         end
      end
   end

   // Drive one instruction, sampled at the next rising edge; returns 1ns after that edge.
   task automatic present(input logic beq, input logic bne, input logic j, input logic z,
                          input logic [31:0] pc, input logic [31:0] imm, input logic [25:0] ja);
      ex_beq = beq; ex_bne = bne; ex_jump = j; ex_zero = z;
      ex_pc_plus4 = pc; ex_imm = imm; ex_jaddr = ja; ex_valid = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_beq = 1'b0; ex_bne = 1'b0; ex_jump = 1'b0;
   endtask

   task automatic count_busy(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (busy === 1'b1) cnt++;
      end
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      check(nm, sb.size(), 0);
   endtask

   initial begin
      int bc;
      #12;
      check("rst_pcload", {31'd0, pcload}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_target", pc_target, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Taken BEQ: 0x104 + (3<<2) = 0x110; busy for 1 + 2 cycles.
      sb.push_back(32'h0000_0110);
      present(1, 0, 0, 1, 32'h0000_0104, 32'h0000_0003, 26'h0);
      count_busy(8, bc);
      check("beq_busy_cycles", bc, 3);
      drain("beq_drain");

      // Untaken BNE: no activity.
      present(0, 1, 0, 1, 32'h0000_0200, 32'h0000_0010, 26'h0);
      count_busy(5, bc);
      check("bne_untaken_busy", bc, 0);
      check("bne_untaken_pcload", {31'd0, pcload}, 0);

      // Jump, then taken BEQs through REDIRECT/SHADOW/IDLE-return edge are all ignored.
      sb.push_back(32'h1000_0100);
      present(0, 0, 1, 0, 32'h1000_0008, 32'h0, 26'h000_0040);
      ex_beq = 1'b1; ex_zero = 1'b1; ex_pc_plus4 = 32'h0000_0400; ex_imm = 32'h1; ex_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1; ex_valid = 1'b0; ex_beq = 1'b0;
      drain("jump_shadow_drain");
      check("jump_idle_busy", {31'd0, busy}, 0);

      // Wrapping target with 3 stalled REDIRECT cycles: pcload held 4 cycles.
      repeat (4) sb.push_back(32'hFFFF_FFFC);
      present(1, 0, 0, 1, 32'h0000_0000, 32'hFFFF_FFFF, 26'h0);
      stall = 1'b1;
      repeat (3) @(posedge clk);
      #1; stall = 1'b0;
      count_busy(8, bc);
      check("stall_busy_after_release", bc, 3);
      drain("stall_drain");

      // Async reset while pcload is high.
      sb.push_back(32'h0000_0204);
      present(1, 0, 0, 1, 32'h0000_0200, 32'h0000_0001, 26'h0);
      @(negedge clk); #1;
      check("pre_rst_pcload", {31'd0, pcload}, 1);
      rst_n = 1'b0; #1;
      check("async_rst_pcload", {31'd0, pcload}, 0);
      check("async_rst_busy", {31'd0, busy}, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      sb.push_back(32'h0000_0308);
      present(1, 0, 0, 1, 32'h0000_0300, 32'h0000_0002, 26'h0);
      drain("post_rst_drain");

      // Perf segment from a fresh reset: 3 taken, 2 untaken, 1 taken in SHADOW.
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      sb.push_back(32'h0000_0014);
      present(1, 0, 0, 1, 32'h0000_0010, 32'h0000_0001, 26'h0);
      @(posedge clk); #1;
      present(1, 0, 0, 1, 32'h0000_0800, 32'h0000_0001, 26'h0);
      drain("perf_a_drain");
      sb.push_back(32'h0000_0010);
      present(0, 1, 0, 0, 32'h0000_0020, 32'hFFFF_FFFC, 26'h0);
      drain("perf_b_drain");
      sb.push_back(32'h0800_0000);
      present(0, 0, 1, 0, 32'h0000_0030, 32'h0, 26'h200_0000);
      drain("perf_c_drain");
      present(0, 1, 0, 1, 32'h0000_0040, 32'h1, 26'h0);
      present(1, 0, 0, 0, 32'h0000_0044, 32'h1, 26'h0);
      drain("perf_untaken_drain");
`ifdef BRU_PERF_CNT_EN
      check("perf_branches", perf_branches, 32'd5);
      check("perf_taken", perf_taken, 32'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
